// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned FWD_W   = 2;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic exe_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic exe_mem_flush;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_INIT   = ctrl_t'(8'b0000_1111);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(8'b0000_0001);
    localparam ctrl_t CTRL_BRANCH = ctrl_t'(8'b1111_1100);
    localparam ctrl_t CTRL_HAZARD = ctrl_t'(8'b0011_0100);
    localparam ctrl_t CTRL_NORMAL = ctrl_t'(8'b1111_0000);

    // A written, nonzero destination that matches a source register.
    function automatic logic reg_hit(input logic [REG_W-1:0] dst, input logic wr,
                                     input logic [REG_W-1:0] src);
        return wr && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-field and control bundle between the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if;
    logic [4:0] IF_ID_Rs, IF_ID_Rt;
    logic [4:0] ID_EX_Rs, ID_EX_Rt, ID_EX_DstReg;
    logic       ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0] EXE_MEM_DstReg;
    logic       EXE_MEM_RegWrite, EXE_MEM_MemAccess;
    logic [4:0] MEM_WB_DstReg;
    logic       MEM_WB_RegWrite;
    logic       BranchTaken, MemReady;
    logic       PC_En, IF_ID_En, ID_EX_En, EXE_MEM_En;
    logic       IF_ID_Flush, ID_EX_Flush, EXE_MEM_Flush, MEM_WB_Bubble;
    logic [1:0] FwdA, FwdB;
    logic       MemTimeout;
    logic [15:0] StallCycles;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_DstReg,
               ID_EX_RegWrite, ID_EX_MemRead, EXE_MEM_DstReg, EXE_MEM_RegWrite,
               EXE_MEM_MemAccess, MEM_WB_DstReg, MEM_WB_RegWrite, BranchTaken, MemReady,
        input  PC_En, IF_ID_En, ID_EX_En, EXE_MEM_En, IF_ID_Flush, ID_EX_Flush,
               EXE_MEM_Flush, MEM_WB_Bubble, FwdA, FwdB, MemTimeout, StallCycles
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_DstReg,
               ID_EX_RegWrite, ID_EX_MemRead, EXE_MEM_DstReg, EXE_MEM_RegWrite,
               EXE_MEM_MemAccess, MEM_WB_DstReg, MEM_WB_RegWrite, BranchTaken, MemReady,
        output PC_En, IF_ID_En, ID_EX_En, EXE_MEM_En, IF_ID_Flush, ID_EX_Flush,
               EXE_MEM_Flush, MEM_WB_Bubble, FwdA, FwdB, MemTimeout, StallCycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// ALU operand bypass select; the EXE/MEM result is younger and wins over MEM/WB.
module forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_ex_rs,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] exe_mem_dst,
    input  logic             exe_mem_wr,
    input  logic [REG_W-1:0] mem_wb_dst,
    input  logic             mem_wb_wr,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b
);

    function automatic logic [FWD_W-1:0] pick(input logic [REG_W-1:0] src,
                                              input logic [REG_W-1:0] m_dst, input logic m_wr,
                                              input logic [REG_W-1:0] w_dst, input logic w_wr);
        if (reg_hit(m_dst, m_wr, src))      return FWD_MEM;
        else if (reg_hit(w_dst, w_wr, src)) return FWD_WB;
        else                                return FWD_REG;
    endfunction

    assign fwd_a = pick(id_ex_rs, exe_mem_dst, exe_mem_wr, mem_wb_dst, mem_wb_wr);
    assign fwd_b = pick(id_ex_rt, exe_mem_dst, exe_mem_wr, mem_wb_dst, mem_wb_wr);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline.
// Define PIPE_FWD_EN to build operand forwarding; otherwise RAW hazards stall until write-back.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d, wait_inc_c;
    logic [STALL_W-1:0] stall_cycles_q, stall_cycles_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               load_use_c, hazard_c;
    logic [FWD_W-1:0]   fwd_a_c, fwd_b_c;
    ctrl_t              run_ctrl_c, ctrl_c;

    assign load_use_c = reg_hit(bus.ID_EX_DstReg, bus.ID_EX_MemRead, bus.IF_ID_Rs) ||
                        reg_hit(bus.ID_EX_DstReg, bus.ID_EX_MemRead, bus.IF_ID_Rt);

`ifdef PIPE_FWD_EN
    forward_unit u_fwd (
        .id_ex_rs    (bus.ID_EX_Rs),
        .id_ex_rt    (bus.ID_EX_Rt),
        .exe_mem_dst (bus.EXE_MEM_DstReg),
        .exe_mem_wr  (bus.EXE_MEM_RegWrite),
        .mem_wb_dst  (bus.MEM_WB_DstReg),
        .mem_wb_wr   (bus.MEM_WB_RegWrite),
        .fwd_a       (fwd_a_c),
        .fwd_b       (fwd_b_c)
    );
    assign hazard_c = load_use_c;
    logic unused_c;
    assign unused_c = bus.ID_EX_RegWrite;
`else
    // Without bypass, any in-flight producer in EX or MEM blocks the consumer in ID.
    assign fwd_a_c  = FWD_REG;
    assign fwd_b_c  = FWD_REG;
    assign hazard_c = load_use_c ||
                      reg_hit(bus.ID_EX_DstReg,   bus.ID_EX_RegWrite,   bus.IF_ID_Rs) ||
                      reg_hit(bus.ID_EX_DstReg,   bus.ID_EX_RegWrite,   bus.IF_ID_Rt) ||
                      reg_hit(bus.EXE_MEM_DstReg, bus.EXE_MEM_RegWrite, bus.IF_ID_Rs) ||
                      reg_hit(bus.EXE_MEM_DstReg, bus.EXE_MEM_RegWrite, bus.IF_ID_Rt);
    logic unused_c;
    assign unused_c = ^{bus.ID_EX_Rs, bus.ID_EX_Rt, bus.MEM_WB_DstReg, bus.MEM_WB_RegWrite};
`endif

    assign run_ctrl_c = bus.BranchTaken ? CTRL_BRANCH :
                        hazard_c        ? CTRL_HAZARD : CTRL_NORMAL;
    assign wait_inc_c = wait_cnt_q + WAIT_W'(1);

    // Next state, counters and Mealy controls.
    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        stall_cycles_d = stall_cycles_q;
        ctrl_c         = CTRL_FREEZE;

        unique case (state_q)
            ST_INIT: begin
                ctrl_c     = CTRL_INIT;
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.EXE_MEM_MemAccess && !bus.MemReady) begin
                    ctrl_c     = CTRL_FREEZE;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    ctrl_c = run_ctrl_c;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.MemReady) begin
                    ctrl_c     = CTRL_FREEZE;
                    wait_cnt_d = wait_inc_c;
                    if (wait_inc_c == WAIT_W'(TIMEOUT)) begin
                        state_d       = ST_ERROR;
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    ctrl_c     = run_ctrl_c;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                ctrl_c        = CTRL_FREEZE;
                mem_timeout_d = 1'b1;
            end
        endcase

        if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !ctrl_c.pc_en &&
            (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + STALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            init_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign bus.PC_En         = ctrl_c.pc_en;
    assign bus.IF_ID_En      = ctrl_c.if_id_en;
    assign bus.ID_EX_En      = ctrl_c.id_ex_en;
    assign bus.EXE_MEM_En    = ctrl_c.exe_mem_en;
    assign bus.IF_ID_Flush   = ctrl_c.if_id_flush;
    assign bus.ID_EX_Flush   = ctrl_c.id_ex_flush;
    assign bus.EXE_MEM_Flush = ctrl_c.exe_mem_flush;
    assign bus.MEM_WB_Bubble = ctrl_c.mem_wb_bubble;
    assign bus.FwdA          = fwd_a_c;
    assign bus.FwdB          = fwd_b_c;
    assign bus.MemTimeout    = mem_timeout_q;
    assign bus.StallCycles   = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors, expected responses queued.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.INIT_CYCLES(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // {PC_En, IF_ID_En, ID_EX_En, EXE_MEM_En, IF_ID_Flush, ID_EX_Flush, EXE_MEM_Flush, MEM_WB_Bubble}
    localparam logic [7:0] E_INIT   = 8'b0000_1111;
    localparam logic [7:0] E_FREEZE = 8'b0000_0001;
    localparam logic [7:0] E_BRANCH = 8'b1111_1100;
    localparam logic [7:0] E_HAZARD = 8'b0011_0100;
    localparam logic [7:0] E_NORMAL = 8'b1111_0000;

`ifdef PIPE_FWD_EN
    localparam logic [7:0] E_RAW   = E_NORMAL;
    localparam logic       RAW_STL = 1'b0;
    localparam logic [1:0] FA_BOTH = 2'b10, FB_WB = 2'b01;
`else
    localparam logic [7:0] E_RAW   = E_HAZARD;
    localparam logic       RAW_STL = 1'b1;
    localparam logic [1:0] FA_BOTH = 2'b00, FB_WB = 2'b00;
`endif

    typedef struct {
        string       tag;
        logic [7:0]  ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        tmo;
        logic [15:0] stall;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_stall = 16'd0;
    logic        exp_tmo   = 1'b0;
    logic        stim_done = 1'b0;

    task automatic idle_inputs();
        bus.IF_ID_Rs = 5'd0; bus.IF_ID_Rt = 5'd0;
        bus.ID_EX_Rs = 5'd0; bus.ID_EX_Rt = 5'd0; bus.ID_EX_DstReg = 5'd0;
        bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_MemRead = 1'b0;
        bus.EXE_MEM_DstReg = 5'd0; bus.EXE_MEM_RegWrite = 1'b0; bus.EXE_MEM_MemAccess = 1'b0;
        bus.MEM_WB_DstReg = 5'd0; bus.MEM_WB_RegWrite = 1'b0;
        bus.BranchTaken = 1'b0; bus.MemReady = 1'b1;
    endtask

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic step(input string tag, input logic [7:0] ctrl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic stalls);
        exp_t e;
        e.tag = tag; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.tmo = exp_tmo; e.stall = exp_stall;
        sb.push_back(e);
        if (stalls) exp_stall = exp_stall + 16'd1;
        @(posedge clk); #1;
    endtask

    // Monitor: controls are valid every cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t        e;
                logic [7:0]  act;
                e   = sb.pop_front();
                act = {bus.PC_En, bus.IF_ID_En, bus.ID_EX_En, bus.EXE_MEM_En,
                       bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EXE_MEM_Flush, bus.MEM_WB_Bubble};
                n_cmp++;
                if (act !== e.ctrl || bus.FwdA !== e.fa || bus.FwdB !== e.fb ||
                    bus.MemTimeout !== e.tmo || bus.StallCycles !== e.stall) begin
                    n_err++;
                    $display("FAIL %s: got ctrl=%b fwd=%b/%b tmo=%b stall=%0d, want ctrl=%b fwd=%b/%b tmo=%b stall=%0d",
                             e.tag, act, bus.FwdA, bus.FwdB, bus.MemTimeout, bus.StallCycles,
                             e.ctrl, e.fa, e.fb, e.tmo, e.stall);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        step("reset0", E_INIT, 2'b00, 2'b00, 1'b0);
        step("reset1", E_INIT, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("init", E_INIT, 2'b00, 2'b00, 1'b0);
        step("run_first", E_NORMAL, 2'b00, 2'b00, 1'b0);

        // Load-use on Rs
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_DstReg = 5'd8;
        bus.IF_ID_Rs = 5'd8;
        step("load_use", E_HAZARD, 2'b00, 2'b00, 1'b1);
        idle_inputs();
        step("after_load_use", E_NORMAL, 2'b00, 2'b00, 1'b0);
        // Load into r0 never stalls
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_DstReg = 5'd0;
        step("load_r0", E_NORMAL, 2'b00, 2'b00, 1'b0);
        idle_inputs();
        // ALU producer in EX, consumer Rs
        bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_DstReg = 5'd10; bus.IF_ID_Rs = 5'd10;
        step("raw_ex", E_RAW, 2'b00, 2'b00, RAW_STL);
        idle_inputs();
        // ALU producer in MEM, consumer Rt
        bus.EXE_MEM_RegWrite = 1'b1; bus.EXE_MEM_DstReg = 5'd9; bus.IF_ID_Rt = 5'd9;
        step("raw_mem", E_RAW, 2'b00, 2'b00, RAW_STL);
        idle_inputs();
        // Producer in WB never stalls ID
        bus.MEM_WB_RegWrite = 1'b1; bus.MEM_WB_DstReg = 5'd11; bus.IF_ID_Rs = 5'd11;
        step("raw_wb", E_NORMAL, 2'b00, 2'b00, 1'b0);
        idle_inputs();

        // Memory wait 3 cycles
        bus.EXE_MEM_MemAccess = 1'b1; bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) step("mem_wait", E_FREEZE, 2'b00, 2'b00, 1'b1);
        bus.MemReady = 1'b1;
        step("mem_release", E_NORMAL, 2'b00, 2'b00, 1'b0);
        idle_inputs();
        step("after_mem", E_NORMAL, 2'b00, 2'b00, 1'b0);

        // Branch held in frozen EX, acted on only when memory completes
        bus.EXE_MEM_MemAccess = 1'b1; bus.MemReady = 1'b0; bus.BranchTaken = 1'b1;
        for (int i = 0; i < 2; i++) step("br_wait", E_FREEZE, 2'b00, 2'b00, 1'b1);
        bus.MemReady = 1'b1;
        step("br_release", E_BRANCH, 2'b00, 2'b00, 1'b0);
        idle_inputs();
        // Branch beats load-use
        bus.BranchTaken = 1'b1; bus.ID_EX_MemRead = 1'b1; bus.ID_EX_DstReg = 5'd3;
        bus.IF_ID_Rt = 5'd3;
        step("br_over_hazard", E_BRANCH, 2'b00, 2'b00, 1'b0);
        idle_inputs();

        // Forwarding selection
        bus.EXE_MEM_RegWrite = 1'b1; bus.EXE_MEM_DstReg = 5'd5;
        bus.MEM_WB_RegWrite = 1'b1; bus.MEM_WB_DstReg = 5'd5; bus.ID_EX_Rs = 5'd5;
        step("fwd_mem_prio", E_NORMAL, FA_BOTH, 2'b00, 1'b0);
        bus.MEM_WB_DstReg = 5'd7; bus.ID_EX_Rt = 5'd7;
        step("fwd_a_mem_b_wb", E_NORMAL, FA_BOTH, FB_WB, 1'b0);
        bus.EXE_MEM_DstReg = 5'd0; bus.MEM_WB_DstReg = 5'd0; bus.ID_EX_Rs = 5'd0; bus.ID_EX_Rt = 5'd0;
        step("fwd_r0", E_NORMAL, 2'b00, 2'b00, 1'b0);
        idle_inputs();

        // Memory timeout
        bus.EXE_MEM_MemAccess = 1'b1; bus.MemReady = 1'b0;
        for (int i = 0; i < 64; i++) step("timeout_wait", E_FREEZE, 2'b00, 2'b00, 1'b1);
        exp_tmo = 1'b1;
        step("error0", E_FREEZE, 2'b00, 2'b00, 1'b0);
        step("error1", E_FREEZE, 2'b00, 2'b00, 1'b0);
        bus.MemReady = 1'b1;
        step("error_sticky", E_FREEZE, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b0;
        step("error_in_reset", E_FREEZE, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1; idle_inputs(); exp_tmo = 1'b0; exp_stall = 16'd0;
        for (int i = 0; i < 4; i++) step("reinit", E_INIT, 2'b00, 2'b00, 1'b0);
        step("rerun", E_NORMAL, 2'b00, 2'b00, 1'b0);

        // Reset mid-wait goes to INIT even with MemReady high
        bus.EXE_MEM_MemAccess = 1'b1; bus.MemReady = 1'b0;
        step("wait_pre_rst", E_FREEZE, 2'b00, 2'b00, 1'b1);
        rst_n = 1'b0; bus.MemReady = 1'b1;
        step("wait_rst", E_NORMAL, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1; idle_inputs(); exp_stall = 16'd0;
        step("init_after_wait_rst", E_INIT, 2'b00, 2'b00, 1'b0);
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100000, want finished");
        $fatal(1);
    end

endmodule
